// File: rtl/wb_retire_queue_pkg.sv
// Shared constants for the write-back retire queue: source channel indices and default widths.
package wb_retire_queue_pkg;

    localparam int SRC_EX  = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_CSR = 2;

    localparam int DEF_NSRC    = 3;
    localparam int DEF_XLEN    = 64;
    localparam int DEF_RADDR_W = 5;
    localparam int DEF_DEPTH   = 4;

endpackage

// File: rtl/wb_retire_queue_if.sv
// Upstream retire handshake plus register-file write port of the retire queue.
interface wb_retire_queue_if
    import wb_retire_queue_pkg::*;
#(
    parameter int NSRC    = DEF_NSRC,
    parameter int XLEN    = DEF_XLEN,
    parameter int RADDR_W = DEF_RADDR_W
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [NSRC-1:0]        src_wen;
    logic [NSRC*XLEN-1:0]   src_wdata;
    logic [RADDR_W-1:0]     in_rd;
    logic                   flush;
    logic                   rf_stall;
    logic                   rf_wen;
    logic [RADDR_W-1:0]     rf_waddr;
    logic [XLEN-1:0]        rf_wdata;
    logic [63:0]            commit_cnt;
    logic                   err_multi;

    modport master (
        output in_valid, src_wen, src_wdata, in_rd, flush, rf_stall,
        input  in_ready, rf_wen, rf_waddr, rf_wdata, commit_cnt, err_multi
    );

    modport slave (
        input  in_valid, src_wen, src_wdata, in_rd, flush, rf_stall,
        output in_ready, rf_wen, rf_waddr, rf_wdata, commit_cnt, err_multi
    );

endinterface

// File: rtl/wb_src_sel.sv
// Lowest-index-wins selection of write-back data across source channels, plus multi-hot detect.
module wb_src_sel #(
    parameter int NSRC = 3,
    parameter int XLEN = 64
) (
    input  logic [NSRC-1:0]      wen,
    input  logic [NSRC*XLEN-1:0] wdata,
    output logic                 any_wen,
    output logic [XLEN-1:0]      sel_data,
    output logic                 multi_hot
);

    logic [NSRC-1:0] lower_any;
    logic [NSRC-1:0] grant;
    logic [NSRC-1:0] dup;
    logic [XLEN-1:0] masked [NSRC];

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            if (gi == 0) begin : g_first
                assign lower_any[gi] = 1'b0;
            end else begin : g_rest
                assign lower_any[gi] = |wen[gi-1:0];
            end
            // A source wins only if no lower-index source is also writing.
            assign grant[gi]  = wen[gi] & ~lower_any[gi];
            assign dup[gi]    = wen[gi] &  lower_any[gi];
            assign masked[gi] = {XLEN{grant[gi]}} & wdata[gi*XLEN +: XLEN];
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            sel_data = sel_data | masked[i];
        end
    end

    assign any_wen   = |wen;
    assign multi_hot = |dup;

endmodule

// File: rtl/wb_retire_queue.sv
// In-order retire queue: captures one write-back per accepted instruction and drains it to the
// register file one entry per unstalled cycle through registered outputs.
module wb_retire_queue
    import wb_retire_queue_pkg::*;
#(
    parameter int NSRC    = DEF_NSRC,
    parameter int XLEN    = DEF_XLEN,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    wb_retire_queue_if.slave  bus
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + RADDR_W + XLEN;

    logic [ENTRY_W-1:0] entry_mem [DEPTH];

    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [OCC_W-1:0]   occ_reg;
    logic               live_reg;
    logic               rf_wen_reg;
    logic [RADDR_W-1:0] rf_waddr_reg;
    logic [XLEN-1:0]    rf_wdata_reg;
    logic [63:0]        commit_cnt_reg;
    logic               err_multi_reg;

    logic               any_wen;
    logic               multi_hot;
    logic [XLEN-1:0]    sel_data;
    logic               new_wen;
    logic [ENTRY_W-1:0] new_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               accept;
    logic               pop;

    wb_src_sel #(
        .NSRC (NSRC),
        .XLEN (XLEN)
    ) u_src_sel (
        .wen       (bus.src_wen),
        .wdata     (bus.src_wdata),
        .any_wen   (any_wen),
        .sel_data  (sel_data),
        .multi_hot (multi_hot)
    );

    // Writes to x0 are retired as no-ops so they still count but never reach the register file.
    assign new_wen   = any_wen & (bus.in_rd != '0);
    assign new_entry = {new_wen, bus.in_rd, new_wen ? sel_data : {XLEN{1'b0}}};

    // live_reg keeps in_ready low until the first edge after reset; no input feeds in_ready.
    assign bus.in_ready = live_reg & (occ_reg < OCC_W'(DEPTH));
    assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
    assign pop          = (occ_reg != '0) & ~bus.rf_stall & ~bus.flush;
    assign head_entry   = entry_mem[head_reg];

    always_ff @(posedge clk) begin
        if (accept) begin
            entry_mem[tail_reg] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            occ_reg        <= '0;
            live_reg       <= 1'b0;
            rf_wen_reg     <= 1'b0;
            rf_waddr_reg   <= '0;
            rf_wdata_reg   <= '0;
            commit_cnt_reg <= '0;
            err_multi_reg  <= 1'b0;
        end else begin
            live_reg <= 1'b1;
            if (bus.flush) begin
                head_reg <= '0;
                tail_reg <= '0;
                occ_reg  <= '0;
            end else begin
                if (accept) begin
                    tail_reg <= tail_reg + 1'b1;
                end
                if (pop) begin
                    head_reg <= head_reg + 1'b1;
                end
                case ({accept, pop})
                    2'b10:   occ_reg <= occ_reg + 1'b1;
                    2'b01:   occ_reg <= occ_reg - 1'b1;
                    default: occ_reg <= occ_reg;
                endcase
            end

            if (pop) begin
                {rf_wen_reg, rf_waddr_reg, rf_wdata_reg} <= head_entry;
                commit_cnt_reg <= commit_cnt_reg + 64'd1;
            end else begin
                rf_wen_reg   <= 1'b0;
                rf_waddr_reg <= '0;
                rf_wdata_reg <= '0;
            end

            if (accept && multi_hot) begin
                err_multi_reg <= 1'b1;
            end
        end
    end

    assign bus.rf_wen     = rf_wen_reg;
    assign bus.rf_waddr   = rf_waddr_reg;
    assign bus.rf_wdata   = rf_wdata_reg;
    assign bus.commit_cnt = commit_cnt_reg;
    assign bus.err_multi  = err_multi_reg;

endmodule

// File: tb/tb_wb_retire_queue.sv
// Self-checking bench for wb_retire_queue: table vectors, directed corner sequences and a
// randomized run, all compared against a queue-based reference model.
module tb_wb_retire_queue;

    localparam int NSRC  = 3;
    localparam int XLEN  = 64;
    localparam int RW    = 5;
    localparam int DEPTH = 4;

    typedef struct {
        logic          wen;
        logic [RW-1:0] addr;
        logic [63:0]   data;
    } ent_t;

    typedef struct {
        int            cyc;
        logic [RW-1:0] addr;
        logic [63:0]   data;
    } wr_t;

    typedef struct {
        logic [2:0]  wen;
        logic [63:0] d0, d1, d2;
        logic [4:0]  rd;
        logic        e_wen;
        logic [4:0]  e_addr;
        logic [63:0] e_data;
        logic        e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    wb_retire_queue_if #(.NSRC(NSRC), .XLEN(XLEN), .RADDR_W(RW)) bus ();

    wb_retire_queue #(
        .NSRC(NSRC), .XLEN(XLEN), .RADDR_W(RW), .DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state
    ent_t        q[$];
    wr_t         wlog[$];
    ent_t        m_out;
    logic [63:0] m_cnt;
    logic        m_err;
    logic        m_live;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_out  = '{default: '0};
        m_cnt  = '0;
        m_err  = 1'b0;
        m_live = 1'b0;
    endtask

    // Drives one cycle of inputs, advances the model, then checks the outputs after the edge.
    task automatic cycle(input logic v, input logic [2:0] wen, input logic [63:0] d0,
                         input logic [63:0] d1, input logic [63:0] d2, input logic [4:0] rd,
                         input logic fl, input logic st, output logic acc);
        logic        ready;
        logic        pop;
        ent_t        e;
        ent_t        nout;
        logic [63:0] d [3];
        bus.in_valid  = v;
        bus.src_wen   = wen;
        bus.src_wdata = {d2, d1, d0};
        bus.in_rd     = rd;
        bus.flush     = fl;
        bus.rf_stall  = st;
        ready = m_live && (q.size() < DEPTH);
        chk("in_ready", bus.in_ready, ready);
        acc = v && ready && !fl;
        pop = (q.size() > 0) && !st && !fl;
        d[0] = d0; d[1] = d1; d[2] = d2;
        e.wen  = (wen != 3'b000) && (rd != 5'd0);
        e.addr = rd;
        e.data = '0;
        for (int i = 2; i >= 0; i--) if (wen[i]) e.data = d[i];
        if (!e.wen) e.data = '0;
        nout = '{default: '0};
        if (pop) nout = q.pop_front();
        if (fl) q.delete();
        else if (acc) q.push_back(e);
        if (acc && ($countones(wen) > 1)) m_err = 1'b1;
        if (pop) m_cnt = m_cnt + 64'd1;
        m_out  = nout;
        m_live = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        chk("rf_out", {bus.rf_wen, bus.rf_waddr, bus.rf_wdata}, {m_out.wen, m_out.addr, m_out.data});
        chk("commit_cnt", bus.commit_cnt, m_cnt);
        chk("err_multi", bus.err_multi, m_err);
        if (bus.rf_wen) wlog.push_back('{cyc, bus.rf_waddr, bus.rf_wdata});
    endtask

    task automatic idle(input logic st);
        logic a;
        cycle(1'b0, 3'b000, 64'h0, 64'h0, 64'h0, 5'd0, 1'b0, st, a);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rf_wen"}, bus.rf_wen, 1'b0);
        chk({tag, "_rf_waddr"}, bus.rf_waddr, 5'd0);
        chk({tag, "_rf_wdata"}, bus.rf_wdata, 64'd0);
        chk({tag, "_cnt"}, bus.commit_cnt, 64'd0);
        chk({tag, "_err"}, bus.err_multi, 1'b0);
        chk({tag, "_ready"}, bus.in_ready, 1'b0);
    endtask

    vec_t        tv[6];
    logic        acc;
    logic [63:0] cnt_before;
    wr_t         exp_w[$];
    int          n;

    initial begin
        bus.in_valid = 1'b0; bus.src_wen = '0; bus.src_wdata = '0; bus.in_rd = '0;
        bus.flush = 1'b0; bus.rf_stall = 1'b0;
        model_reset();

        tv[0] = '{3'b010, 64'h0, 64'hDEAD_BEEF, 64'h0, 5'd5, 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0};
        tv[1] = '{3'b011, 64'h1, 64'h2, 64'h0, 5'd7, 1'b1, 5'd7, 64'h1, 1'b1};
        tv[2] = '{3'b001, 64'h9, 64'h0, 64'h0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1};
        tv[3] = '{3'b100, 64'h0, 64'h0, 64'h55AA, 5'd31, 1'b1, 5'd31, 64'h55AA, 1'b1};
        tv[4] = '{3'b000, 64'h3, 64'h4, 64'h5, 5'd3, 1'b0, 5'd3, 64'h0, 1'b1};
        tv[5] = '{3'b110, 64'h0, 64'h77, 64'h88, 5'd12, 1'b1, 5'd12, 64'h77, 1'b1};

        // Power-on reset: outputs clear without any clock edge.
        rst = 1'b1;
        #1 rst = 1'b0;
        #2 check_reset_state("por");
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        idle(1'b0);
        chk("ready_after_rst", bus.in_ready, 1'b1);

        // Table vectors: each retire lands exactly two cycles after its accept.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, tv[i].wen, tv[i].d0, tv[i].d1, tv[i].d2, tv[i].rd, 1'b0, 1'b0, acc);
            chk("tbl_t1_wen", bus.rf_wen, 1'b0);
            idle(1'b0);
            chk("tbl_out", {bus.rf_wen, bus.rf_waddr, bus.rf_wdata},
                {tv[i].e_wen, tv[i].e_addr, tv[i].e_data});
            chk("tbl_err", bus.err_multi, tv[i].e_err);
            chk("tbl_cnt", bus.commit_cnt, 64'(i + 1));
            idle(1'b0);
            chk("tbl_t3_wen", bus.rf_wen, 1'b0);
        end

        // Full under stall: only four of five pushes fit; drain is back-to-back and in order.
        wlog.delete();
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 3'b001, 64'h100 + 64'(k), 64'h0, 64'h0, 5'(k + 1), 1'b0, 1'b1, acc);
            if (k == 3) chk("full_ready_low", bus.in_ready, 1'b0);
        end
        chk("full_still_low", bus.in_ready, 1'b0);
        idle(1'b0);
        chk("ready_after_pop", bus.in_ready, 1'b1);
        repeat (5) idle(1'b0);
        chk("full_nwrites", wlog.size(), 4);
        for (int k = 0; k < 4 && k < wlog.size(); k++) begin
            chk("full_order", {wlog[k].addr, wlog[k].data}, {5'(k + 1), 64'h100 + 64'(k)});
            chk("full_consec", wlog[k].cyc, wlog[0].cyc + k);
        end

        // Flush: queued entries and the flushed-cycle input are dropped.
        wlog.delete();
        cnt_before = 64'd10;
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 3'b001, 64'h200 + 64'(k), 64'h0, 64'h0, 5'(9 + k), 1'b0, 1'b1, acc);
        cycle(1'b1, 3'b100, 64'h0, 64'h0, 64'h333, 5'd20, 1'b1, 1'b0, acc);
        repeat (5) idle(1'b0);
        chk("flush_nwrites", wlog.size(), 0);
        chk("flush_cnt", bus.commit_cnt, cnt_before);
        for (int k = 0; k < 4; k++)
            cycle(1'b1, 3'b001, 64'h1, 64'h0, 64'h0, 5'd1, 1'b0, 1'b1, acc);
        chk("flush_occ_zero", bus.in_ready, 1'b0);
        cycle(1'b0, 3'b000, 64'h0, 64'h0, 64'h0, 5'd0, 1'b1, 1'b1, acc);

        // Async reset mid-cycle while a write is on the outputs and one entry is still queued.
        cycle(1'b1, 3'b010, 64'h0, 64'hAAAA, 64'h0, 5'd13, 1'b0, 1'b1, acc);
        cycle(1'b1, 3'b010, 64'h0, 64'hBBBB, 64'h0, 5'd14, 1'b0, 1'b1, acc);
        idle(1'b0);
        chk("pre_rst_wen", bus.rf_wen, 1'b1);
        #1 rst = 1'b0;
        #1 check_reset_state("arst");
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        model_reset();
        wlog.delete();
        repeat (4) idle(1'b0);
        chk("arst_nwrites", wlog.size(), 0);
        chk("arst_ready", bus.in_ready, 1'b1);
        chk("arst_cnt", bus.commit_cnt, 64'd0);

        // Wrap: ten entries through a depth-4 queue with random one-cycle stalls.
        wlog.delete();
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            logic [2:0]  w;
            logic [4:0]  rd;
            logic [63:0] a0, a1, a2;
            w  = 3'($urandom);
            rd = 5'($urandom);
            a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom}; a2 = {$urandom, $urandom};
            cycle(1'b1, w, a0, a1, a2, rd, 1'b0, ($urandom % 3) == 0, acc);
            if (acc) begin
                n++;
                if (w != 3'b000 && rd != 5'd0)
                    exp_w.push_back('{0, rd, w[0] ? a0 : (w[1] ? a1 : a2)});
            end
        end
        chk("wrap_accepts", n, 10);
        for (int c = 0; c < 12; c++) idle(c < 4 ? (($urandom % 2) == 1) : 1'b0);
        chk("wrap_cnt", bus.commit_cnt, 64'd10);
        chk("wrap_nwrites", wlog.size(), exp_w.size());
        for (int k = 0; k < exp_w.size() && k < wlog.size(); k++)
            chk("wrap_seq", {wlog[k].addr, wlog[k].data}, {exp_w[k].addr, exp_w[k].data});

        // Long random run with flushes, stalls and multi-hot enables.
        for (int c = 0; c < 400; c++) begin
            cycle(($urandom % 4) != 0, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, 5'($urandom), ($urandom % 20) == 0, ($urandom % 4) == 0, acc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_retire_queue.md
WB_RETIRE_QUEUE -- requirements
Module: wb_retire_queue

Interface
REQ-001 SHALL have parameter NSRC, default 3, giving the number of write-back source channels (index 0 = EX, 1 = MEM, 2 = CSR); legal range 1..8.
REQ-002 SHALL have parameter XLEN, default 64, giving the data width.
REQ-003 SHALL have parameter RADDR_W, default 5, giving the register address width.
REQ-004 SHALL have parameter DEPTH, default 4, giving the queue depth; power of 2, at least 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream holds a retiring instruction.
REQ-008 SHALL have port in_ready, output, 1 bit: the queue can accept an instruction this cycle.
REQ-009 SHALL have port src_wen, input, NSRC bits: per-source write enables.
REQ-010 SHALL have port src_wdata, input, NSRC*XLEN bits: per-source write data; source i occupies bits [i*XLEN +: XLEN].
REQ-011 SHALL have port in_rd, input, RADDR_W bits: destination register.
REQ-012 SHALL have port flush, input, 1 bit: discard all queued, unretired entries.
REQ-013 SHALL have port rf_stall, input, 1 bit: the register file cannot take a write this cycle.
REQ-014 SHALL have port rf_wen, output, 1 bit: register-file write enable.
REQ-015 SHALL have port rf_waddr, output, RADDR_W bits: register-file write address.
REQ-016 SHALL have port rf_wdata, output, XLEN bits: register-file write data.
REQ-017 SHALL have port commit_cnt, output, 64 bits: count of retired entries.
REQ-018 SHALL have port err_multi, output, 1 bit: sticky flag, set when more than one src_wen bit was high at an accept.

Function
REQ-019 An accept SHALL occur in any cycle where in_valid & in_ready & !flush.
REQ-020 On accept, the lowest-index asserted src_wen bit SHALL select the data; the entry SHALL store wen = |src_wen & (in_rd != 0), addr = in_rd, and data = the selected source (0 if wen = 0).
REQ-021 If more than one src_wen bit is high at accept, err_multi SHALL be set to 1 and stay set until reset; the priority rule still applies.
REQ-022 in_ready SHALL equal (occupancy < DEPTH) and SHALL be registered-state only, with no combinational path from in_valid, rf_stall or flush; when full there is no same-cycle pop credit.
REQ-023 A pop SHALL occur on any cycle where occupancy > 0, rf_stall = 0 and flush = 0; at most one pop per cycle.
REQ-024 A pop SHALL load the head entry into the output registers, so rf_wen/rf_waddr/rf_wdata are valid for exactly the following cycle.
REQ-025 In every cycle without a pop, the output registers SHALL load rf_wen = 0, rf_waddr = 0 and rf_wdata = 0.
REQ-026 rf_wdata SHALL be 0 whenever rf_wen = 0.
REQ-027 Latency SHALL be 2 cycles: an accept in cycle T into an empty, unstalled queue gives rf_wen high in cycle T+2.
REQ-028 Order SHALL be strictly FIFO.
REQ-029 Simultaneous accept and pop SHALL leave occupancy unchanged.
REQ-030 Pointers SHALL wrap modulo DEPTH.
REQ-031 Every pop SHALL increment commit_cnt by 1, including entries with wen = 0; the count wraps at 2^64.
REQ-032 flush SHALL take priority over accept and pop in the same cycle: occupancy and both pointers go to 0, the input is dropped, and the output registers load 0.
REQ-033 While rf_stall = 1, the queue SHALL hold its head, outputs SHALL read 0, and accepts continue until the queue is full.

Reset
REQ-034 While rst = 0, the block SHALL asynchronously clear pointers and occupancy, rf_wen, rf_waddr, rf_wdata, commit_cnt and err_multi to 0, and drive in_ready = 0.
REQ-035 After rst rises, in_ready SHALL become 1 from the first clock edge; queue storage contents need no reset.
REQ-036 Reset asserted mid-operation SHALL abandon all queued entries with no further rf_wen pulses.

Structure
REQ-037 The shared defines package SHALL hold the source indices (SRC_EX = 0, SRC_MEM = 1, SRC_CSR = 2) and the default XLEN and RADDR_W.
REQ-038 A single sub-module, wb_src_sel (combinational priority select plus multi-hot detect), SHALL be used; the queue and output registers stay in the top module.

Verification
REQ-039 Single retire: src_wen = 3'b010, src_wdata[MEM] = 64'hDEAD_BEEF, in_rd = 5 in cycle T -> rf_wen = 1, rf_waddr = 5, rf_wdata = 64'hDEAD_BEEF in T+2 only; commit_cnt = 1.
REQ-040 Priority and x0: src_wen = 3'b011 with EX = 1 and MEM = 2, rd = 7 -> data 1 and err_multi = 1; then rd = 0 with EX = 9 -> rf_wen stays 0 and commit_cnt still increments.
REQ-041 Full and stall: rf_stall = 1 and push 5 entries back-to-back -> 4 accepted, in_ready = 0 after the 4th; release stall -> 4 writes on consecutive cycles in order; in_ready returns 1 the cycle after the first pop.
REQ-042 Flush: queue 3 entries, assert flush together with in_valid -> no rf_wen pulses follow, occupancy 0, flushed-cycle input lost.
REQ-043 Async reset: drop rst mid-cycle with 2 entries queued -> all outputs 0 immediately without a clock edge; after release, in_ready = 1 and commit_cnt = 0.
REQ-044 Wrap: DEPTH = 4, stream 10 entries with random 1-cycle stalls -> data and address sequence matches a reference queue exactly; commit_cnt = 10.
